// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants: ImmSrc format codes (identical to the
// decode-side immediate extender), the canonical NOP and major opcodes,
// plus the bundle of decoded fields carried through the encoder pipeline.
package riscv_pkg;

    // ImmSrc format codes; 3'b110 and 3'b111 are illegal
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_R = 3'b101;

    // addi x0, x0, 0 -- substituted for any word with an illegal format code
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    // Decoded fields of one instruction, in input-port order
    typedef struct packed {
        logic [2:0]  imm_src;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
    } instr_fields_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational field packer: scatters the immediate into the bit layout of
// the selected format and flags immediates that the format cannot represent.
// Out-of-range immediates are still packed from their truncated bits so the
// consumer sees a well-formed word alongside the error flag.
module imm_pack
    import riscv_pkg::*;
(
    input  instr_fields_t i_fields,
    output logic [31:0]   o_instr,
    output logic          o_err
);

    logic [31:0] w_imm;
    logic        w_fit_12;   // fits a 12-bit signed field (I/S)
    logic        w_fit_13;   // fits a 13-bit signed field (B)
    logic        w_fit_21;   // fits a 21-bit signed field (J)
    logic        w_low_zero; // low 12 bits clear (U)

    assign w_imm      = i_fields.imm;
    assign w_fit_12   = (&w_imm[31:11]) | ~(|w_imm[31:11]);
    assign w_fit_13   = (&w_imm[31:12]) | ~(|w_imm[31:12]);
    assign w_fit_21   = (&w_imm[31:20]) | ~(|w_imm[31:20]);
    assign w_low_zero = ~(|w_imm[11:0]);

    // Format-dependent packing and range check; illegal codes yield a NOP with error
    always_comb begin
        o_instr = NOP_INSTR;
        o_err   = 1'b1;
        case (i_fields.imm_src)
            IMM_I: begin
                o_instr = {w_imm[11:0], i_fields.rs1, i_fields.funct3,
                           i_fields.rd, i_fields.opcode};
                o_err   = ~w_fit_12;
            end
            IMM_S: begin
                o_instr = {w_imm[11:5], i_fields.rs2, i_fields.rs1, i_fields.funct3,
                           w_imm[4:0], i_fields.opcode};
                o_err   = ~w_fit_12;
            end
            IMM_B: begin
                o_instr = {w_imm[12], w_imm[10:5], i_fields.rs2, i_fields.rs1,
                           i_fields.funct3, w_imm[4:1], w_imm[11], i_fields.opcode};
                o_err   = ~w_fit_13 | w_imm[0];
            end
            IMM_U: begin
                o_instr = {w_imm[31:12], i_fields.rd, i_fields.opcode};
                o_err   = ~w_low_zero;
            end
            IMM_J: begin
                o_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                           i_fields.rd, i_fields.opcode};
                o_err   = ~w_fit_21 | w_imm[0];
            end
            IMM_R: begin
                o_instr = {i_fields.funct7, i_fields.rs2, i_fields.rs1,
                           i_fields.funct3, i_fields.rd, i_fields.opcode};
                o_err   = 1'b0;
            end
            default: begin
                o_instr = NOP_INSTR;
                o_err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encode.sv
// Streaming RISC-V instruction assembler. Stage 1 captures the decoded
// fields, stage 2 holds the packed word and its error flag. Each stage
// advances when the stage downstream of it is empty or draining, so the
// pipeline holds two entries under backpressure and moves one per cycle
// otherwise. Output/error counters saturate instead of wrapping.
module instr_encode
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            ImmSrc,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [6:0]            funct7,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  out_err,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    instr_fields_t         w_in_fields;
    instr_fields_t         r_s1_fields;
    logic                  r_s1_valid;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_instr;
    logic                  r_s2_err;
    logic [CNT_WIDTH-1:0]  r_out_count;
    logic [CNT_WIDTH-1:0]  r_err_count;

    logic [31:0]           w_packed;
    logic                  w_packed_err;
    logic                  w_s2_adv;
    logic                  w_in_ready;
    logic                  w_xfer;

    assign w_in_fields = {ImmSrc, imm, opcode, rd, funct3, rs1, rs2, funct7};

    // Handshake: stage 2 frees up when empty or being consumed; stage 1 when
    // empty or moving into stage 2. Independent of in_valid by construction.
    assign w_s2_adv   = ~r_s2_valid | out_ready;
    assign w_in_ready = ~r_s1_valid | w_s2_adv;
    assign w_xfer     = r_s2_valid & out_ready;

    imm_pack u_imm_pack (
        .i_fields (r_s1_fields),
        .o_instr  (w_packed),
        .o_err    (w_packed_err)
    );

    // Stage 1: capture fields on accept; clears when its entry moves on with no replacement
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_fields <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_fields <= w_in_fields;
            end
        end
    end

    // Stage 2: register packed word and error; frozen while stalled so output stays stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_instr <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_instr <= w_packed;
                r_s2_err   <= w_packed_err;
            end
        end
    end

    // Saturating counters of handed-off words and of those flagged as errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_count <= '0;
            r_err_count <= '0;
        end else if (w_xfer) begin
            if (r_out_count != '1) begin
                r_out_count <= r_out_count + CNT_ONE;
            end
            if (r_s2_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + CNT_ONE;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign instr     = r_s2_instr;
    assign out_err   = r_s2_err;
    assign out_count = r_out_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encode.sv
// Directed testbench for instr_encode. A default build (16-bit counters)
// and a 4-bit-counter build share the same stimulus; the small build is
// used to reach counter saturation quickly.
`timescale 1ns/1ps
module tb_instr_encode;
    import riscv_pkg::*;

    localparam int NUM_VEC = 19;
    localparam int NUM_ERR = 9;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  ImmSrc    = 3'b000;
    logic [31:0] imm       = 32'h0;
    logic [6:0]  opcode    = 7'h0;
    logic [4:0]  rd        = 5'h0;
    logic [2:0]  funct3    = 3'h0;
    logic [4:0]  rs1       = 5'h0;
    logic [4:0]  rs2       = 5'h0;
    logic [6:0]  funct7    = 7'h0;

    logic        in_ready,  in_ready_s;
    logic        out_valid, out_valid_s;
    logic [31:0] instr,     instr_s;
    logic        out_err,   out_err_s;
    logic [15:0] out_count, err_count;
    logic [3:0]  out_count_s, err_count_s;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [NUM_VEC];
    vec_t bp   [3];

    always #5 clk = ~clk;

    instr_encode #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ImmSrc(ImmSrc), .imm(imm), .opcode(opcode), .rd(rd), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .funct7(funct7), .out_valid(out_valid),
        .out_ready(out_ready), .instr(instr), .out_err(out_err),
        .out_count(out_count), .err_count(err_count)
    );

    instr_encode #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .ImmSrc(ImmSrc), .imm(imm), .opcode(opcode), .rd(rd), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .funct7(funct7), .out_valid(out_valid_s),
        .out_ready(out_ready), .instr(instr_s), .out_err(out_err_s),
        .out_count(out_count_s), .err_count(err_count_s)
    );

    function automatic vec_t mk(input logic [2:0] src, input logic [31:0] im,
                                input logic [6:0] opc, input logic [4:0] d,
                                input logic [2:0] f3, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [6:0] f7,
                                input logic [31:0] ei, input logic ee);
        vec_t v;
        v.src = src; v.imm = im; v.opc = opc; v.rd = d; v.f3 = f3;
        v.rs1 = s1; v.rs2 = s2; v.f7 = f7; v.exp_instr = ei; v.exp_err = ee;
        return v;
    endfunction

    // Hand-encoded vectors; fields a format ignores are set to junk on purpose
    task automatic init_vectors();
        vecs[0]  = mk(IMM_I, 32'hFFFF_FFFF, OPC_OP_IMM, 5'd1,  3'd0, 5'd0,  5'd31, 7'h7F, 32'hFFF0_0093, 1'b0);
        vecs[1]  = mk(IMM_B, 32'h0000_0008, OPC_BRANCH, 5'd31, 3'd0, 5'd1,  5'd2,  7'h7F, 32'h0020_8463, 1'b0);
        vecs[2]  = mk(IMM_I, 32'h0000_0800, OPC_OP_IMM, 5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'h8000_0093, 1'b1);
        vecs[3]  = mk(IMM_I, 32'h0000_07FF, OPC_OP_IMM, 5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'h7FF0_0093, 1'b0);
        vecs[4]  = mk(IMM_I, 32'hFFFF_F800, OPC_OP_IMM, 5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'h8000_0093, 1'b0);
        vecs[5]  = mk(IMM_S, 32'hFFFF_FFFC, OPC_STORE,  5'd31, 3'd2, 5'd2,  5'd5,  7'h7F, 32'hFE51_2E23, 1'b0);
        vecs[6]  = mk(IMM_S, 32'h0000_0800, OPC_STORE,  5'd31, 3'd2, 5'd2,  5'd5,  7'h00, 32'h8051_2023, 1'b1);
        vecs[7]  = mk(IMM_B, 32'h0000_0009, OPC_BRANCH, 5'd31, 3'd0, 5'd1,  5'd2,  7'h00, 32'h0020_8463, 1'b1);
        vecs[8]  = mk(IMM_B, 32'h0000_1000, OPC_BRANCH, 5'd31, 3'd0, 5'd1,  5'd2,  7'h00, 32'h8020_8063, 1'b1);
        vecs[9]  = mk(IMM_B, 32'hFFFF_F000, OPC_BRANCH, 5'd31, 3'd0, 5'd1,  5'd2,  7'h00, 32'h8020_8063, 1'b0);
        vecs[10] = mk(IMM_U, 32'h1234_5000, OPC_LUI,    5'd5,  3'd7, 5'd31, 5'd31, 7'h7F, 32'h1234_52B7, 1'b0);
        vecs[11] = mk(IMM_U, 32'h1234_5001, OPC_LUI,    5'd5,  3'd7, 5'd31, 5'd31, 7'h7F, 32'h1234_52B7, 1'b1);
        vecs[12] = mk(IMM_J, 32'h0000_0800, OPC_JAL,    5'd1,  3'd7, 5'd31, 5'd31, 7'h7F, 32'h0010_00EF, 1'b0);
        vecs[13] = mk(IMM_J, 32'hFFFF_FFFE, OPC_JAL,    5'd0,  3'd7, 5'd31, 5'd31, 7'h7F, 32'hFFFF_F06F, 1'b0);
        vecs[14] = mk(IMM_J, 32'h0010_0000, OPC_JAL,    5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'h8000_00EF, 1'b1);
        vecs[15] = mk(IMM_J, 32'h0000_0003, OPC_JAL,    5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'h0020_00EF, 1'b1);
        vecs[16] = mk(IMM_R, 32'hFFFF_FFFF, OPC_OP,     5'd1,  3'd0, 5'd2,  5'd3,  7'h20, 32'h4031_00B3, 1'b0);
        vecs[17] = mk(3'b111, 32'h0000_0000, OPC_OP_IMM, 5'd1, 3'd0, 5'd0,  5'd0,  7'h00, 32'h0000_0013, 1'b1);
        vecs[18] = mk(3'b110, 32'h0000_0005, OPC_OP,    5'd2,  3'd1, 5'd3,  5'd4,  7'h01, 32'h0000_0013, 1'b1);
        bp[0] = mk(IMM_I, 32'h1, OPC_OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0010_0093, 1'b0);
        bp[1] = mk(IMM_I, 32'h1, OPC_OP_IMM, 5'd2, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0010_0113, 1'b0);
        bp[2] = mk(IMM_I, 32'h1, OPC_OP_IMM, 5'd3, 3'd0, 5'd0, 5'd0, 7'h00, 32'h0010_0193, 1'b0);
    endtask

    task automatic drive_vec(input vec_t v);
        ImmSrc = v.src; imm = v.imm; opcode = v.opc; rd = v.rd; funct3 = v.f3;
        rs1 = v.rs1; rs2 = v.rs2; funct7 = v.f7; in_valid = 1'b1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One word in, then wait until it has been handed off (out_ready assumed 1)
    task automatic send_and_drain(input vec_t v);
        @(posedge clk); #1; drive_vec(v);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || instr !== 32'h0 || out_err !== 1'b0 || in_ready !== 1'b1 ||
            out_count !== 16'h0 || err_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b instr=%h out_err=%b in_ready=%b out_count=%0d err_count=%0d, required 0 0 0 1 0 0",
                     out_valid, instr, out_err, in_ready, out_count, err_count);
        end
        $display("test_reset: out_valid=%b in_ready=%b out_count=%0d", out_valid, in_ready, out_count);
    endtask

    task automatic test_formats();
        apply_reset();
        for (int i = 0; i < NUM_VEC; i++) begin
            @(posedge clk); #1; drive_vec(vecs[i]);
            @(posedge clk); #1; in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL latency_vec%0d: out_valid=%b one cycle after accept, required 0", i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || instr !== vecs[i].exp_instr || out_err !== vecs[i].exp_err) begin
                failures++;
                $display("FAIL pack_vec%0d: out_valid=%b instr=%h out_err=%b, required 1 %h %b",
                         i, out_valid, instr, out_err, vecs[i].exp_instr, vecs[i].exp_err);
            end
            $display("test_formats vec%0d: src=%b imm=%h instr=%h err=%b", i, vecs[i].src, vecs[i].imm, instr, out_err);
        end
        @(negedge clk);
        checks++;
        if (out_count !== 16'(NUM_VEC) || err_count !== 16'(NUM_ERR)) begin
            failures++;
            $display("FAIL format_counts: out_count=%0d err_count=%0d, required %0d %0d",
                     out_count, err_count, NUM_VEC, NUM_ERR);
        end
    endtask

    task automatic test_err_counts();
        apply_reset();
        send_and_drain(vecs[2]);
        checks++;
        if (out_count !== 16'd1 || err_count !== 16'd1) begin
            failures++;
            $display("FAIL err_count_range: out_count=%0d err_count=%0d, required 1 1", out_count, err_count);
        end
        send_and_drain(vecs[0]);
        checks++;
        if (out_count !== 16'd2 || err_count !== 16'd1) begin
            failures++;
            $display("FAIL err_count_clean: out_count=%0d err_count=%0d, required 2 1", out_count, err_count);
        end
        send_and_drain(vecs[17]);
        checks++;
        if (out_count !== 16'd3 || err_count !== 16'd2) begin
            failures++;
            $display("FAIL err_count_illegal: out_count=%0d err_count=%0d, required 3 2", out_count, err_count);
        end
        $display("test_err_counts: out_count=%0d err_count=%0d", out_count, err_count);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < NUM_VEC + 2; i++) begin
            @(posedge clk); #1;
            if (i < NUM_VEC) drive_vec(vecs[i]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (i < NUM_VEC) begin
                checks++;
                if (in_ready !== 1'b1 || in_ready_s !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready%0d: in_ready=%b in_ready_small=%b, required 1 1", i, in_ready, in_ready_s);
                end
            end
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || instr !== vecs[i-2].exp_instr || out_err !== vecs[i-2].exp_err ||
                    out_valid_s !== 1'b1 || instr_s !== vecs[i-2].exp_instr || out_err_s !== vecs[i-2].exp_err) begin
                    failures++;
                    $display("FAIL b2b_out%0d: valid=%b instr=%h err=%b small=%b/%h/%b, required 1 %h %b",
                             i - 2, out_valid, instr, out_err, out_valid_s, instr_s, out_err_s,
                             vecs[i-2].exp_instr, vecs[i-2].exp_err);
                end
                $display("test_back_to_back out%0d: instr=%h err=%b", i - 2, instr, out_err);
            end
        end
        @(negedge clk);
        checks++;
        if (out_count !== 16'(NUM_VEC) || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count: out_count=%0d out_valid=%b, required %0d 0", out_count, out_valid, NUM_VEC);
        end
    endtask

    task automatic test_backpressure();
        int  idx;
        int  received;
        bit  acc;
        apply_reset();
        out_ready = 1'b0;
        @(posedge clk); #1; drive_vec(bp[0]);
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) drive_vec(bp[idx]);
                else in_valid = 1'b0;
            end
        end
        checks++;
        if (idx !== 2) begin
            failures++;
            $display("FAIL bp_accepted: accepted=%0d under stall, required 2", idx);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || instr !== bp[0].exp_instr) begin
                failures++;
                $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b instr=%h, required 0 1 %h",
                         c, in_ready, out_valid, instr, bp[0].exp_instr);
            end
            $display("test_backpressure hold%0d: in_ready=%b instr=%h", c, in_ready, instr);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        received = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (received >= 3) begin
                    failures++;
                    $display("FAIL bp_dup: extra word instr=%h after 3, required none", instr);
                end else if (instr !== bp[received].exp_instr) begin
                    failures++;
                    $display("FAIL bp_order%0d: instr=%h, required %h", received, instr, bp[received].exp_instr);
                end
                $display("test_backpressure drain%0d: instr=%h", received, instr);
                received++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) drive_vec(bp[idx]);
                else in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (received !== 3 || idx !== 3 || out_count !== 16'd3) begin
            failures++;
            $display("FAIL bp_total: received=%0d accepted=%0d out_count=%0d, required 3 3 3", received, idx, out_count);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        send_and_drain(bp[0]);
        checks++;
        if (out_count !== 16'd1) begin
            failures++;
            $display("FAIL mid_pre_count: out_count=%0d, required 1", out_count);
        end
        out_ready = 1'b0;
        @(posedge clk); #1; drive_vec(bp[1]);
        @(posedge clk); #1; drive_vec(bp[2]);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_full: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
        end
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_count !== 16'd0 || err_count !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: out_valid=%b out_count=%0d err_count=%0d in_ready=%b, required 0 0 0 1",
                     out_valid, out_count, err_count, in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_ghost%0d: out_valid=%b instr=%h after reset, required 0", c, out_valid, instr);
            end
        end
        $display("test_reset_midflight: out_valid=%b out_count=%0d", out_valid, out_count);
    endtask

    task automatic test_saturation();
        apply_reset();
        @(posedge clk); #1; drive_vec(vecs[17]);
        repeat (18) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_count_s !== 4'hF || err_count_s !== 4'hF) begin
            failures++;
            $display("FAIL sat_small: out_count=%h err_count=%h, required f f", out_count_s, err_count_s);
        end
        checks++;
        if (out_count !== 16'd18 || err_count !== 16'd18 || out_valid_s !== 1'b0) begin
            failures++;
            $display("FAIL sat_wide: out_count=%0d err_count=%0d small_valid=%b, required 18 18 0",
                     out_count, err_count, out_valid_s);
        end
        $display("test_saturation: small=%h/%h wide=%0d/%0d", out_count_s, err_count_s, out_count, err_count);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        init_vectors();
        test_reset();
        test_formats();
        test_err_counts();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encode.md
Name: instr_encode

Overview:
- Streaming RISC-V instruction assembler: the inverse of the decode-side immediate extender.
- Takes decoded fields, a full 32-bit immediate and an ImmSrc format code, then packs a legal 32-bit instruction word.
- Used by the instruction-memory loader and the self-test generator.
- Two-stage valid/ready pipeline with backpressure, immediate range checking and saturating statistics counters.

Parameters:
- DATA_WIDTH, 32, instruction/immediate width. Only 32 is supported.
- CNT_WIDTH, 16, width of the output and error counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input fields valid
- in_ready  out  1  block can accept input this cycle
- ImmSrc  in  3  format code: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R; 110/111 illegal
- imm  in  DATA_WIDTH  full sign-extended immediate (byte offset for B/J)
- opcode  in  7  instr[6:0]
- rd  in  5  destination register
- funct3  in  3  funct3 field
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct7  in  7  funct7 field (R only)
- out_valid  out  1  instr valid
- out_ready  in  1  consumer accepts instr
- instr  out  DATA_WIDTH  packed instruction
- out_err  out  1  immediate out of range or illegal ImmSrc for this instr
- out_count  out  CNT_WIDTH  instructions handed off
- err_count  out  CNT_WIDTH  handed-off instructions with out_err=1

Behaviour:
- Reset: synchronous, active-low; clk is the only clock. When rst_n=0 at a clk edge:
  - s1_valid, s2_valid, out_valid ← 0
  - instr ← 0, out_err ← 0
  - out_count, err_count ← 0
  - in-flight entries are dropped.
  - in_ready is 1 in the cycle after reset.
- Stage 1 registers the input fields and ImmSrc.
- Stage 2 registers the packed word and the error bit; out_valid = s2_valid.
- Handshakes:
  - s2_adv = !s2_valid | out_ready
  - in_ready = !s1_valid | s2_adv (combinational; no dependence on in_valid)
  - An input is accepted when in_valid & in_ready.
  - An output transfers when out_valid & out_ready.
- Latency is 2 cycles from accept to out_valid. Throughput is 1 per cycle when out_ready=1.
- Under out_ready=0 the block holds at most 2 entries. instr and out_err stay stable while out_valid=1 and out_ready=0.
- Packing, bit positions MSB→LSB:
  - I: imm[11:0], rs1, funct3, rd, opcode
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode
  - U: imm[31:12], rd, opcode
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode
  - R: funct7, rs2, rs1, funct3, rd, opcode (imm ignored)
- Range check; out_err=1 when:
  - I/S: imm[31:11] is not all-equal.
  - B: imm[31:12] is not all-equal, or imm[0]≠0.
  - U: imm[11:0]≠0.
  - J: imm[31:20] is not all-equal, or imm[0]≠0.
  - R: never.
  - On a range error the word is still packed from truncated bits.
- Illegal ImmSrc (110/111): instr = 32'h0000_0013 (NOP), out_err=1.
- Counters:
  - out_count increments on each output transfer.
  - err_count increments on transfers with out_err=1.
  - Both saturate at all-ones and never wrap.
- Simultaneous accept and output transfer in the same cycle are both honoured: the pipeline shifts.

Decomposition:
- Shared package (riscv_pkg) holds the ImmSrc localparams (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R), the NOP constant 32'h0000_0013, and the opcode constants. The decode-side extender uses the same ImmSrc codes.
- One combinational sub-module, imm_pack, does field packing plus the range check (fields and ImmSrc in → word and err out). This keeps the pipeline/handshake logic separate and lets imm_pack be tested exhaustively on its own.

Test Plan:
- I-type: ImmSrc=000, imm=32'hFFFF_FFFF, opcode=7'h13, rd=1, rs1=0, funct3=0, out_ready=1 → 2 cycles later instr=32'hFFF0_0093, out_err=0, out_count=1.
- B-type: ImmSrc=010, imm=8, rs1=1, rs2=2, funct3=0, opcode=7'h63 → instr=32'h0020_8463, out_err=0.
- Range error: ImmSrc=000, imm=32'h0000_0800, rd=1, rs1=0, opcode=7'h13 → instr=32'h8000_0093, out_err=1, err_count=1. Then ImmSrc=111 → instr=32'h0000_0013, out_err=1, err_count=2.
- Backpressure: out_ready=0 with 3 back-to-back valid inputs → 2 accepted, then in_ready=0 and instr stable. Raise out_ready → all 3 emerge in order, out_count=3, no loss or duplication.
- Reset mid-operation: with both stages full, drive rst_n=0 for one clk → next cycle out_valid=0, out_count=0, err_count=0, in_ready=1. The in-flight words never appear.
- Saturation: force 2^CNT_WIDTH+2 transfers (or use a reduced CNT_WIDTH=4 build with 18 transfers) → out_count stays at 4'hF.
